axilite_master: RTL and testbench
=================================

# axilite_master

AXI4-Lite initiator that turns a simple single-beat command/response interface into AXI4-Lite read and write transactions. It sits between the coprocessor's sequencer logic and AXI4-Lite responders such as the per-cell register blocks, and issues exactly one outstanding transaction at a time.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 32, data width; must be 32 (strobe width DATA_W/8 = 4)

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  reset: one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_we  out  1  echo of cmd_we
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  AXI RRESP/BRESP
- awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready  AXI4-Lite write channels (master side)
- araddr, arvalid, arready, rdata, rresp, rvalid, rready  AXI4-Lite read channels (master side)
- err_count  out  16  only with AXILITE_MASTER_ERRCNT_EN

## Operation
- States: IDLE, WRITE (AW/W outstanding), WRESP, READ (AR outstanding), RDATA, RSP.
- IDLE: cmd_ready=1. On cmd handshake, command fields are registered; cmd_we=1 -> WRITE, else -> READ.
- WRITE: awvalid and wvalid both asserted. Each channel is deasserted independently on its own handshake, so AW and W may complete in either order or together. Once both complete -> WRESP.
- WRESP: bready=1. On bvalid, bresp is captured -> RSP.
- READ: arvalid=1 until arready -> RDATA.
- RDATA: rready=1. On rvalid, rdata and rresp are captured -> RSP.
- RSP: rsp_valid=1, outputs stable until rsp_ready. Then -> IDLE.
- AXI payloads (awaddr/wdata/wstrb/araddr) come from registers, are stable while the corresponding valid is high, and are never changed before handshake.
- Valids never depend combinationally on readys.
- Non-OKAY responses are passed through unchanged and are not retried.

## Timing
- Reset (async assert, sync release): state IDLE; cmd_ready=1 once released; all valids, bready, rready, and rsp_valid are 0; rsp_rdata, rsp_resp, rsp_we, and err_count are 0. Asserting reset mid-transaction drops all valids immediately and discards the transaction.
- All outputs are registered, except cmd_ready, which decodes state.
- Write with zero-wait responder: cmd handshake at cycle 0; awvalid/wvalid at cycle 1; bready at cycle 2; rsp_valid at cycle 3. Minimum latency is 3 cycles.
- Read with zero-wait responder: arvalid at 1, rready at 2, rsp_valid at 3.
- Every responder wait cycle adds exactly one cycle.
- cmd_ready is 0 from the cycle after acceptance until the cycle after the rsp handshake. Back-to-back commands are therefore spaced ≥4 cycles.
- rsp_ready held low: FSM stalls in RSP and no new command is accepted.

## Configuration
- AXILITE_MASTER_ERRCNT_EN defined: err_count port exists. It increments by 1 on each captured bresp/rresp ≠ OKAY and saturates at 16'hFFFF. It resets to 0.
- Undefined: no err_count port and no counter logic. Behaviour is otherwise identical.

## Structure
- Shared package axilite_pkg holds:
  - resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11)
  - master state enum
  - strobe-width constant
- Single module; no sub-module (the FSM and capture registers are tightly coupled).

## Test plan
- Write 0x0 / 0x11223344 / strobe 1111, zero-wait responder -> awaddr=0, wdata=0x11223344, wstrb=1111 on the bus; rsp_valid at cycle 3, rsp_we=1, rsp_resp=OKAY.
- Write 0x4 / 0x55667788 / strobe 1011, with wready arriving 3 cycles before awready -> wvalid drops first, awvalid is held, exactly one B accepted, then read 0x4 returns 0x55007788 from a strobe-honouring responder.
- Read 0x0 with arready delayed 2 cycles and rvalid delayed 5 cycles -> arvalid stable throughout, rsp_rdata=0x11223344, rsp_valid exactly once.
- Responder returns SLVERR on a read -> rsp_resp=2'b10; err_count 0->1 with ERRCNT_EN; without the macro there is no port and the bench compiles.
- areset pulsed while awvalid is high, then a fresh read issued -> all valids 0 asynchronously, cmd_ready=1 after release, and the new read completes normally.
- rsp_ready held low for 10 cycles with cmd_valid high -> rsp fields stable and cmd_ready=0 throughout.

Source files
------------

// File: rtl/axilite_pkg.sv
// axilite_pkg: shared AXI4-Lite response codes, master FSM states and strobe width
package axilite_pkg;
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        READ,
        RDATA,
        RSP
    } state_t;

    localparam int STRB_W = 4;
endpackage

// File: rtl/axilite_master.sv
// axilite_master: single-outstanding AXI4-Lite initiator driven by a cmd/rsp handshake interface
// Ports: aclk/areset (async active-high); cmd_* request in (cmd_ready decodes IDLE);
// rsp_* registered response out; aw/w/b and ar/r AXI4-Lite master channels;
// err_count (non-OKAY response counter, saturating) only when AXILITE_MASTER_ERRCNT_EN is defined.
module axilite_master
    import axilite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
`ifdef AXILITE_MASTER_ERRCNT_EN
    ,
    output logic [15:0]       err_count
`endif
);
    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_n, rdata_n;
    logic [STRB_W-1:0] wstrb_n;
    logic [1:0]        resp_n;
    logic              we_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n, rsp_valid_n;

    assign cmd_ready = (state == IDLE);
    // one address register feeds both address channels; only one is ever valid
    assign awaddr = addr_q;
    assign araddr = addr_q;

    // every output is the registered copy of its *_n value, so valids never
    // follow readys combinationally
    always_comb begin
        state_n     = state;
        addr_n      = addr_q;
        wdata_n     = wdata;
        wstrb_n     = wstrb;
        we_n        = rsp_we;
        awvalid_n   = awvalid;
        wvalid_n    = wvalid;
        bready_n    = bready;
        arvalid_n   = arvalid;
        rready_n    = rready;
        rsp_valid_n = rsp_valid;
        rdata_n     = rsp_rdata;
        resp_n      = rsp_resp;
        case (state)
            IDLE: if (cmd_valid) begin
                addr_n    = cmd_addr;
                wdata_n   = cmd_wdata;
                wstrb_n   = cmd_wstrb;
                we_n      = cmd_we;
                awvalid_n = cmd_we;
                wvalid_n  = cmd_we;
                arvalid_n = !cmd_we;
                state_n   = cmd_we ? WRITE : READ;
            end
            WRITE: begin
                // AW and W retire independently; B is awaited once both are gone
                awvalid_n = awvalid && !awready;
                wvalid_n  = wvalid && !wready;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    state_n  = WRESP;
                end
            end
            WRESP: if (bvalid) begin
                bready_n    = 1'b0;
                rdata_n     = '0;
                resp_n      = bresp;
                rsp_valid_n = 1'b1;
                state_n     = RSP;
            end
            READ: if (arready) begin
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
                state_n   = RDATA;
            end
            RDATA: if (rvalid) begin
                rready_n    = 1'b0;
                rdata_n     = rdata;
                resp_n      = rresp;
                rsp_valid_n = 1'b1;
                state_n     = RSP;
            end
            RSP: if (rsp_ready) begin
                rsp_valid_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            rsp_we    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            wdata     <= wdata_n;
            wstrb     <= wstrb_n;
            rsp_we    <= we_n;
            awvalid   <= awvalid_n;
            wvalid    <= wvalid_n;
            bready    <= bready_n;
            arvalid   <= arvalid_n;
            rready    <= rready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rdata_n;
            rsp_resp  <= resp_n;
        end
    end

`ifdef AXILITE_MASTER_ERRCNT_EN
    logic bad_resp;

    assign bad_resp = (state == WRESP && bvalid && bresp != OKAY) ||
                      (state == RDATA && rvalid && rresp != OKAY);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            err_count <= '0;
        else if (bad_resp && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_axilite_master.sv
// tb_axilite_master: randomized self-checking bench with a delay-programmable AXI4-Lite responder
module tb_axilite_master;
    import axilite_pkg::*;

    logic        aclk, areset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
`ifdef AXILITE_MASTER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    axilite_master dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
`ifdef AXILITE_MASTER_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    int exp_err = 0;
    int b_count = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0] inj = 2'b00;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] model [logic [31:0]];

    // Responder: acts on negedges; a ready/valid raised here completes on the next posedge.
    initial begin
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_got, w_got, ar_got;
        logic [31:0] aw_a, w_d, ar_a, mask;
        logic [3:0] w_s;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        {aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_got, w_got, ar_got} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        aw_a = 0; w_d = 0; w_s = 0; ar_a = 0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                {aw_pend, w_pend, b_pend, ar_pend, r_pend, aw_got, w_got, ar_got} = '0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (aw_pend) begin aw_pend = 0; awready = 0; aw_got = 1; end
                else if (awvalid && !aw_got) begin
                    if (aw_cnt >= aw_dly) begin awready = 1; aw_a = awaddr; aw_pend = 1; end
                    else aw_cnt++;
                end
                if (w_pend) begin w_pend = 0; wready = 0; w_got = 1; end
                else if (wvalid && !w_got) begin
                    if (w_cnt >= w_dly) begin wready = 1; w_d = wdata; w_s = wstrb; w_pend = 1; end
                    else w_cnt++;
                end
                if (b_pend) begin
                    b_pend = 0; bvalid = 0; aw_got = 0; w_got = 0;
                    aw_cnt = 0; w_cnt = 0; b_cnt = 0; b_count++;
                end else begin
                    if (aw_got && w_got && !bvalid) begin
                        if (b_cnt >= b_dly) begin
                            bvalid = 1; bresp = inj;
                            if (inj == 2'b00) begin
                                mask = {{8{w_s[3]}}, {8{w_s[2]}}, {8{w_s[1]}}, {8{w_s[0]}}};
                                mem[aw_a] = ((mem.exists(aw_a) ? mem[aw_a] : 32'h0) & ~mask) | (w_d & mask);
                            end
                        end else b_cnt++;
                    end
                    if (bvalid && bready) b_pend = 1;
                end
                if (ar_pend) begin ar_pend = 0; arready = 0; ar_got = 1; end
                else if (arvalid && !ar_got) begin
                    if (ar_cnt >= ar_dly) begin arready = 1; ar_a = araddr; ar_pend = 1; end
                    else ar_cnt++;
                end
                if (r_pend) begin
                    r_pend = 0; rvalid = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
                end else begin
                    if (ar_got && !rvalid) begin
                        if (r_cnt >= r_dly) begin
                            rvalid = 1; rresp = inj; rdata = mem.exists(ar_a) ? mem[ar_a] : 32'h0;
                        end else r_cnt++;
                    end
                    if (rvalid && rready) r_pend = 1;
                end
            end
        end
    end

    // One complete transaction: latency and per-channel busy cycles are predicted from the
    // responder delays (each wait cycle adds one), read data from a byte-level memory model.
    task automatic run_cmd(input string nm, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int awd, input int wd, input int bd, input int ard,
                           input int rd, input logic [1:0] rsp, input int hold);
        int lat = 0, aw_hi = 0, w_hi = 0, b_hi = 0, ar_hi = 0, r_hi = 0, bad = 0, hbad = 0, b0, exp_lat;
        logic [31:0] exp_data, o;
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd; inj = rsp; b0 = b_count;
        exp_lat = we ? 3 + (awd > wd ? awd : wd) + bd : 3 + ard + rd;
        exp_data = we ? 32'h0 : (model.exists(a) ? model[a] : 32'h0);
        @(negedge aclk);
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL %s idle_cmd_ready got %b want 1", nm, cmd_ready); end
        cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        @(posedge aclk);
        #1 cmd_valid = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge aclk);
            if (awvalid === 1'b1) aw_hi++;
            if (wvalid === 1'b1) w_hi++;
            if (bready === 1'b1) b_hi++;
            if (arvalid === 1'b1) ar_hi++;
            if (rready === 1'b1) r_hi++;
            if (awvalid === 1'b1 && awaddr !== a) bad++;
            if (wvalid === 1'b1 && (wdata !== d || wstrb !== s)) bad++;
            if (arvalid === 1'b1 && araddr !== a) bad++;
            if (cmd_ready !== 1'b0) bad++;
            if (rsp_valid === 1'b1) begin lat = k; break; end
        end
        tests++;
        if (lat == 0) begin fails++; $display("FAIL %s timeout waiting for rsp_valid", nm); return; end
        if (lat != exp_lat) begin fails++; $display("FAIL %s latency got %0d want %0d", nm, lat, exp_lat); end
        tests++;
        if (aw_hi != (we ? awd + 1 : 0) || w_hi != (we ? wd + 1 : 0)) begin
            fails++; $display("FAIL %s aw/w_valid_cycles got %0d/%0d want %0d/%0d", nm, aw_hi, w_hi, we ? awd + 1 : 0, we ? wd + 1 : 0);
        end
        tests++;
        if (b_hi != (we ? bd + 1 : 0)) begin fails++; $display("FAIL %s bready_cycles got %0d want %0d", nm, b_hi, we ? bd + 1 : 0); end
        tests++;
        if (ar_hi != (we ? 0 : ard + 1) || r_hi != (we ? 0 : rd + 1)) begin
            fails++; $display("FAIL %s ar/r_cycles got %0d/%0d want %0d/%0d", nm, ar_hi, r_hi, we ? 0 : ard + 1, we ? 0 : rd + 1);
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL %s payload/cmd_ready_violations got %0d want 0", nm, bad); end
        tests++;
        if (b_count - b0 != (we ? 1 : 0)) begin fails++; $display("FAIL %s b_handshakes got %0d want %0d", nm, b_count - b0, we ? 1 : 0); end
        tests++;
        if (rsp_we !== we) begin fails++; $display("FAIL %s rsp_we got %b want %b", nm, rsp_we, we); end
        tests++;
        if (rsp_rdata !== exp_data) begin fails++; $display("FAIL %s rsp_rdata got %h want %h", nm, rsp_rdata, exp_data); end
        tests++;
        if (rsp_resp !== rsp) begin fails++; $display("FAIL %s rsp_resp got %b want %b", nm, rsp_resp, rsp); end
        if (we && rsp == 2'b00) begin
            o = model.exists(a) ? model[a] : 32'h0;
            for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = d[8*i +: 8];
            model[a] = o;
        end
        if (rsp != 2'b00 && exp_err < 65535) exp_err++;
`ifdef AXILITE_MASTER_ERRCNT_EN
        tests++;
        if (err_count !== 16'(exp_err)) begin fails++; $display("FAIL %s err_count got %0d want %0d", nm, err_count, exp_err); end
`endif
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                cmd_valid = 1; cmd_we = 1'($urandom_range(0, 1)); cmd_addr = $urandom;
                @(negedge aclk);
                if (rsp_valid !== 1'b1 || rsp_we !== we || rsp_rdata !== exp_data || rsp_resp !== rsp || cmd_ready !== 1'b0) hbad++;
            end
            tests++;
            if (hbad != 0) begin fails++; $display("FAIL %s stall_stability bad_cycles got %0d want 0", nm, hbad); end
        end
        cmd_valid = 0; rsp_ready = 1;
        @(posedge aclk);
        #1 rsp_ready = 0;
        @(negedge aclk);
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL %s after_rsp rsp_valid/cmd_ready got %b/%b want 0/1", nm, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_we} !== 7'b0 || rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
            fails++; $display("FAIL reset_outputs got valids=%b rdata=%h resp=%b want 0", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_we}, rsp_rdata, rsp_resp);
        end
`ifdef AXILITE_MASTER_ERRCNT_EN
        tests++;
        if (err_count !== 16'h0) begin fails++; $display("FAIL reset_err_count got %0d want 0", err_count); end
`endif
        repeat (2) @(negedge aclk);
        #2 areset = 0;
        @(negedge aclk);
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_basic();
        run_cmd("write_zero_wait", 1, 32'h0, 32'h11223344, 4'b1111, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic test_write_w_first();
        run_cmd("write_w_first", 1, 32'h4, 32'h55667788, 4'b1011, 3, 0, 0, 0, 0, 2'b00, 0);
        run_cmd("read_back_strobed", 0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0);
        tests++;
        if (model[32'h4] !== 32'h55007788) begin fails++; $display("FAIL strobe_model got %h want 55007788", model[32'h4]); end
    endtask

    task automatic test_read_delayed();
        run_cmd("read_delayed", 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 2, 5, 2'b00, 0);
    endtask

    task automatic test_slverr();
        run_cmd("read_slverr", 0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 1, 1, SLVERR, 0);
    endtask

    task automatic test_reset_mid();
        aw_dly = 8; w_dly = 8; b_dly = 0; inj = 2'b00;
        @(negedge aclk);
        cmd_we = 1; cmd_addr = 32'h10; cmd_wdata = 32'hdeadbeef; cmd_wstrb = 4'hf; cmd_valid = 1;
        @(posedge aclk);
        #1 cmd_valid = 0;
        @(negedge aclk);
        tests++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin fails++; $display("FAIL reset_mid_pre aw/wvalid got %b/%b want 1/1", awvalid, wvalid); end
        #2 areset = 1;
        #1;
        tests++;
        if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_we} !== 7'b0) begin
            fails++; $display("FAIL reset_mid_async got %b want 0000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_we});
        end
        exp_err = 0;
        @(negedge aclk);
        #2 areset = 0;
        @(negedge aclk);
        tests++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_mid_cmd_ready got %b want 1", cmd_ready); end
        run_cmd("read_after_reset", 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic test_rsp_stall();
        run_cmd("rsp_stall", 0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 10);
    endtask

    task automatic test_random();
        logic we_r;
        logic [31:0] a_r, d_r;
        logic [3:0] s_r;
        logic [1:0] r_r;
        for (int n = 0; n < 24; n++) begin
            we_r = 1'($urandom_range(0, 1));
            a_r = 32'($urandom_range(0, 7)) << 2;
            d_r = $urandom;
            s_r = 4'($urandom_range(1, 15));
            r_r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_cmd("random", we_r, a_r, d_r, s_r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), r_r, $urandom_range(0, 2));
        end
    endtask

    initial begin
        areset = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        test_reset();
        test_write_basic();
        test_write_w_first();
        test_read_delayed();
        test_slverr();
        test_reset_mid();
        test_rsp_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
